// File: rtl/vga_pkg.sv
// Shared raster timing defaults, coordinate widths and total-length helpers for the VGA sync path.
package vga_pkg;

    localparam int COL_W = 11;
    localparam int ROW_W = 10;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N position counter for one raster axis; resets to N-1 so the first enabled edge lands on 0.
module vga_axis_counter #(
    parameter int N = 1344,
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] nxt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;

    assign tc    = (cnt_q == LAST);
    assign count = cnt_q;

    // nxt is the value the counter takes on this edge, so the top can decode flags from it
    always_comb begin
        nxt = cnt_q;
        if (en) begin
            nxt = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: Columna/Fila scan plus HSYNC, VSYNC, VIDEO_ON and FRAME_START.
// Define SYNC_DELAY_EN to delay HSYNC/VSYNC/VIDEO_ON by two enabled edges.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             NCLK,
    input  logic             NRST,
    input  logic             ENA,
    output logic [COL_W-1:0] Columna,
    output logic [ROW_W-1:0] Fila,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             VIDEO_ON,
    output logic             FRAME_START
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COL_W-1:0] HS_START = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0] HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ROW_W-1:0] VS_START = ROW_W'(V_ACTIVE + V_FP);
    localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COL_W-1:0] H_VIS    = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_VIS    = ROW_W'(V_ACTIVE);

    logic [COL_W-1:0] h_count, h_nxt;
    logic [ROW_W-1:0] v_count, v_nxt;
    logic             h_tc, v_tc;

    vga_axis_counter #(.N(H_TOTAL), .W(COL_W)) u_hcnt (
        .clk   (NCLK),
        .rst_n (NRST),
        .en    (ENA),
        .count (h_count),
        .nxt   (h_nxt),
        .tc    (h_tc)
    );

    vga_axis_counter #(.N(V_TOTAL), .W(ROW_W)) u_vcnt (
        .clk   (NCLK),
        .rst_n (NRST),
        .en    (ENA & h_tc),
        .count (v_count),
        .nxt   (v_nxt),
        .tc    (v_tc)
    );

    assign Columna = h_count;
    assign Fila    = v_count;

    logic hs_dec, vs_dec, vid_dec;
    logic hs_q, vs_q, vid_q, fs_q;

    always_comb begin
        hs_dec  = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? H_POL : ~H_POL;
        vs_dec  = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? V_POL : ~V_POL;
        vid_dec = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end

    // Flags decode the next position so they line up with the coordinate registers
    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
            vid_q <= 1'b0;
            fs_q  <= 1'b0;
        end else if (ENA) begin
            hs_q  <= hs_dec;
            vs_q  <= vs_dec;
            vid_q <= vid_dec;
            fs_q  <= h_tc & v_tc;
        end
    end

    assign FRAME_START = fs_q;

`ifdef SYNC_DELAY_EN
    logic [1:0] hs_d, vs_d, vid_d;

    // Two stages match the renderer's two-ROM pixel pipeline
    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            hs_d  <= {2{~H_POL}};
            vs_d  <= {2{~V_POL}};
            vid_d <= 2'b00;
        end else if (ENA) begin
            hs_d  <= {hs_d[0], hs_q};
            vs_d  <= {vs_d[0], vs_q};
            vid_d <= {vid_d[0], vid_q};
        end
    end

    assign HSYNC    = hs_d[1];
    assign VSYNC    = vs_d[1];
    assign VIDEO_ON = vid_d[1];
`else
    assign HSYNC    = hs_q;
    assign VSYNC    = vs_q;
    assign VIDEO_ON = vid_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: default-timing instance plus a tiny-timing instance for frame-level behaviour.
module tb_vga_sync_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hp; bit vp;
    } tim_t;

    typedef struct packed {
        int col; int row;
        bit hs; bit vs; bit vid; bit fs;
    } exp_t;

    localparam tim_t TA = '{ha:1024, hf:24, hs:136, hb:160, va:768, vf:3, vs:6, vb:29, hp:1'b0, vp:1'b0};
    localparam tim_t TB = '{ha:16, hf:2, hs:3, hb:4, va:8, vf:1, vs:2, vb:3, hp:1'b1, vp:1'b1};

`ifdef SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic        NCLK, NRST, ENA;
    logic [10:0] col_a, col_b;
    logic [9:0]  row_a, row_b;
    logic        hs_a, vs_a, vid_a, fs_a;
    logic        hs_b, vs_b, vid_b, fs_b;

    int     n_chk  = 0;
    int     n_fail = 0;
    longint idx    = -1;

    vga_sync_gen dut_a (
        .NCLK(NCLK), .NRST(NRST), .ENA(ENA),
        .Columna(col_a), .Fila(row_a), .HSYNC(hs_a), .VSYNC(vs_a),
        .VIDEO_ON(vid_a), .FRAME_START(fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .NCLK(NCLK), .NRST(NRST), .ENA(ENA),
        .Columna(col_b), .Fila(row_b), .HSYNC(hs_b), .VSYNC(vs_b),
        .VIDEO_ON(vid_b), .FRAME_START(fs_b)
    );

    initial NCLK = 1'b0;
    always #5 NCLK = ~NCLK;

    // idx = number of enabled edges since reset, minus one; -1 means "in reset"
    always @(posedge NCLK or negedge NRST) begin
        if (!NRST) idx <= -1;
        else if (ENA) idx <= idx + 1;
    end

    function automatic exp_t model(input tim_t t, input longint i);
        exp_t   e;
        longint ht = t.ha + t.hf + t.hs + t.hb;
        longint vt = t.va + t.vf + t.vs + t.vb;
        if (i < 0) begin
            e.col = int'(ht - 1);
            e.row = int'(vt - 1);
            e.hs  = !t.hp;
            e.vs  = !t.vp;
            e.vid = 1'b0;
            e.fs  = 1'b0;
        end else begin
            e.col = int'(i % ht);
            e.row = int'((i / ht) % vt);
            e.hs  = (e.col >= t.ha + t.hf && e.col < t.ha + t.hf + t.hs) ? t.hp : !t.hp;
            e.vs  = (e.row >= t.va + t.vf && e.row < t.va + t.vf + t.vs) ? t.vp : !t.vp;
            e.vid = (e.col < t.ha) && (e.row < t.va);
            e.fs  = (e.col == 0) && (e.row == 0);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t idx=%0d)", nm, act, exp, $time, idx);
        end
    endtask

    task automatic cmp(input string nm, input tim_t t, input int col, input int row,
                       input bit hs, input bit vs, input bit vid, input bit fs);
        exp_t e = model(t, idx);
        exp_t d = model(t, idx - DLY);
        chk({nm, "_col"}, col, e.col);
        chk({nm, "_row"}, row, e.row);
        chk({nm, "_fs"},  fs,  e.fs);
        chk({nm, "_hs"},  hs,  d.hs);
        chk({nm, "_vs"},  vs,  d.vs);
        chk({nm, "_vid"}, vid, d.vid);
    endtask

    always @(negedge NCLK) begin
        cmp("a", TA, int'(col_a), int'(row_a), hs_a, vs_a, vid_a, fs_a);
        cmp("b", TB, int'(col_b), int'(row_b), hs_b, vs_b, vid_b, fs_b);
    end

    initial begin
        int  hs_low, vid_cnt, vs_act, fs_a_cnt, fs_b_cnt;
        bit  found;
        ENA  = 1'b0;
        NRST = 1'b0;
        repeat (3) @(negedge NCLK);

        chk("rst_col", col_a, 1343);
        chk("rst_row", row_a, 805);
        chk("rst_hs",  hs_a,  1);
        chk("rst_vs",  vs_a,  1);
        chk("rst_vid", vid_a, 0);
        chk("rst_fs",  fs_a,  0);

        hs_low = 0; vid_cnt = 0; vs_act = 0; fs_a_cnt = 0; fs_b_cnt = 0;
        NRST = 1'b1;
        ENA  = 1'b1;
        for (int k = 0; k < 1400; k++) begin
            @(negedge NCLK);
            if (k == 0) begin
                chk("first_col", col_a, 0);
                chk("first_row", row_a, 0);
                chk("first_fs",  fs_a,  1);
                chk("first_hs",  hs_a,  1);
                chk("first_vs",  vs_a,  1);
            end
            if (k == 1)          chk("second_fs", fs_a, 0);
            if (k == DLY)        chk("first_vid", vid_a, 1);
            if (k == 1023 + DLY) chk("vid_last", vid_a, 1);
            if (k == 1024 + DLY) chk("vid_fall", vid_a, 0);
            if (k == 1047 + DLY) chk("hs_before", hs_a, 1);
            if (k == 1048 + DLY) chk("hs_fall", hs_a, 0);
            if (k == 1183 + DLY) chk("hs_last", hs_a, 0);
            if (k == 1184 + DLY) chk("hs_rise", hs_a, 1);
            if (k == 1343) begin
                chk("eol_col", col_a, 1343);
                chk("eol_row", row_a, 0);
            end
            if (k == 1344) begin
                chk("wrap_col", col_a, 0);
                chk("wrap_row", row_a, 1);
            end
            if (k < 1344 && !hs_a) hs_low++;
            if (k < 1344 && vid_a) vid_cnt++;
            if (k < 350 && vs_b) vs_act++;
            if (fs_a) fs_a_cnt++;
            if (fs_b) fs_b_cnt++;
        end
        chk("hs_low_cycles", hs_low, 136);
        chk("vid_cycles", vid_cnt, 1024);
        chk("b_vs_cycles", vs_act, 50);
        chk("a_fs_pulses", fs_a_cnt, 1);
        chk("b_fs_pulses", fs_b_cnt, 4);

        // ENA alternating: FRAME_START on the small raster must span two clocks per pulse
        fs_b_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge NCLK);
            ENA = ~ENA;
            if (fs_b) fs_b_cnt++;
        end
        chk("alt_fs_even", fs_b_cnt % 2, 0);

        for (int k = 0; k < 3000; k++) begin
            @(negedge NCLK);
            ENA = ($urandom_range(0, 3) != 0);
        end

        ENA   = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge NCLK);
            if (idx >= 0 && (idx % 1344) == 500) found = 1'b1;
        end
        chk("reset_point_found", found, 1);
        if (found) begin
            chk("pre_rst_col", col_a, 500);
            #1 NRST = 1'b0;
            #1;
            chk("mid_rst_col_a", col_a, 1343);
            chk("mid_rst_row_a", row_a, 805);
            chk("mid_rst_hs_a",  hs_a,  1);
            chk("mid_rst_vs_a",  vs_a,  1);
            chk("mid_rst_vid_a", vid_a, 0);
            chk("mid_rst_fs_a",  fs_a,  0);
            chk("mid_rst_col_b", col_b, 24);
            chk("mid_rst_row_b", row_b, 13);
            chk("mid_rst_hs_b",  hs_b,  0);
            #1 NRST = 1'b1;
        end

        for (int k = 0; k < 1000; k++) begin
            @(negedge NCLK);
            ENA = ($urandom_range(0, 4) != 0);
        end

        @(negedge NCLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
